// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states, default widths.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand magnitudes, shift-add multiply / restoring divide step, and sign fix-up of results.
// MULDIV_FAST_MUL_EN replaces the shift-add step with a one-shot combinational product.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             step_mul,
  input  logic             step_div,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc_hi/acc_lo hold {product} for multiply and {remainder, quotient} for divide
  logic [WIDTH-1:0] acc_hi, acc_lo, mag;
  logic             is_div, dz, neg_q, neg_r;
  logic             sgn, div_op, zero_b;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod, nprod;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x, input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  assign sgn    = ~op[0];
  assign div_op = op[1];
  assign zero_b = (src_b == '0);
  assign diff   = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mag};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fprod;
  assign fprod = {{WIDTH{1'b0}}, mag} * {{WIDTH{1'b0}}, acc_lo};
`else
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      mag    <= '0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (load) begin
      is_div <= div_op;
      dz     <= div_op & zero_b;
      neg_q  <= sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r  <= sgn & src_a[WIDTH-1];
      if (div_op && zero_b) begin
        // divide by zero bypasses the iteration: results are fixed here
        acc_hi <= src_a;
        acc_lo <= '1;
        mag    <= '0;
      end else if (div_op) begin
        acc_hi <= '0;
        acc_lo <= mag_of(src_a, sgn);
        mag    <= mag_of(src_b, sgn);
      end else begin
        acc_hi <= '0;
        acc_lo <= mag_of(src_b, sgn);
        mag    <= mag_of(src_a, sgn);
      end
    end else if (step_mul) begin
`ifdef MULDIV_FAST_MUL_EN
      {acc_hi, acc_lo} <= fprod;
`else
      acc_hi <= sum[WIDTH:1];
      acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
`endif
    end else if (step_div) begin
      if (!diff[WIDTH]) begin
        acc_hi <= diff[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign prod  = {acc_hi, acc_lo};
  assign nprod = -prod;

  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (dz) begin
      res_hi = acc_hi;
      res_lo = acc_lo;
    end else if (is_div) begin
      res_lo = neg_q ? -acc_lo : acc_lo;
      res_hi = neg_r ? -acc_hi : acc_hi;
    end else if (neg_q) begin
      {res_hi, res_lo} = nprod;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: FSM, iteration counter, HI/LO, stall and done.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiply).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             accept, last;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign accept = start & ~busy & ~flush;
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign stall  = busy & (start | mf_req);

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept & ~op[2]),
    .op       (op[1:0]),
    .src_a    (src_a),
    .src_b    (src_b),
    .step_mul (state == MUL),
    .step_div (state == DIV),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            cnt <= '0;
            case (muldiv_op_t'(op))
              OP_MULT, OP_MULTU: begin
                state <= MUL;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state <= (src_b == '0) ? FIX : DIV;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
          MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            state <= FIX;
`else
            cnt <= cnt + 1'b1;
            if (last) state <= FIX;
`endif
          end
          DIV: begin
            cnt <= cnt + 1'b1;
            if (last) state <= FIX;
          end
          FIX: begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus stall/flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, mf_req, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mf_req(mf_req), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int done_n, output int done_at);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  initial begin
    int bn, dn, da, exp_lat, dcount;
    bit ok;

    vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[3] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'b011, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[6] = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[7] = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{3'b010, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; mf_req = 1'b0; flush = 1'b0;
    op = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    foreach (vecs[i]) begin
      exp_lat = !vecs[i].op[1] ? MUL_LAT : (vecs[i].b == 0 ? 1 : DIV_LAT);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bn, dn, da);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d busy cycles", i), bn, exp_lat);
      chk($sformatf("vec%0d done cycle", i), da, exp_lat + 1);
      chk($sformatf("vec%0d done pulses", i), dn, 1);
    end

    // start/mf_req while busy stall and are not accepted
    @(negedge clk);
    start = 1'b1; op = 3'b000; src_a = 32'd2; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'b101; src_a = 32'hDEAD;
    #1 chk("stall on start", stall, 1);
    mf_req = 1'b1;
    #1 chk("stall on start+mf", stall, 1);
    start = 1'b0;
    #1 chk("stall on mf_req", stall, 1);
    @(posedge clk);
    #1 mf_req = 1'b0;
    chk("still busy", busy, 1);
    wait_done(ok);
    chk("stall op done seen", ok, 1);
    chk("blocked MTLO ignored lo", lo, 6);

    // back-to-back: mf_req and new start in the done cycle
    @(negedge clk);
    start = 1'b1; op = 3'b001; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(ok);
    chk("b2b first done", ok, 1);
    chk("done cycle busy", busy, 0);
    mf_req = 1'b1; start = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    #1 chk("done cycle stall", stall, 0);
    chk("done cycle lo visible", lo, 42);
    @(posedge clk);
    #1 start = 1'b0; mf_req = 1'b0;
    chk("b2b accepted", busy, 1);
    wait_done(ok);
    chk("b2b second done", ok, 1);
    chk("b2b hi", hi, 2);
    chk("b2b lo", lo, 14);

    // MTHI / MTLO: single edge, no busy, no done
    @(negedge clk);
    start = 1'b1; op = 3'b100; src_a = 32'h1234;
    @(posedge clk);
    #1 chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", busy, 0);
    chk("mthi done", done, 0);
    @(negedge clk);
    op = 3'b101; src_a = 32'h5678;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo lo", lo, 32'h5678);
    chk("mtlo done", done, 0);

    // reserved op 110 changes nothing
    @(negedge clk);
    start = 1'b1; op = 3'b110; src_a = 32'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    chk("op110 busy", busy, 0);
    chk("op110 hi", hi, 32'h1234);
    chk("op110 lo", lo, 32'h5678);

    // flush at iteration 10 of MULTU
    @(negedge clk);
    start = 1'b1; op = 3'b001; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pre-flush busy", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush busy", busy, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("flush no done", dcount, 0);
    chk("flush hi kept", hi, 32'h1234);
    chk("flush lo kept", lo, 32'h5678);

    // flush during FIX suppresses the divide-by-zero write
    @(negedge clk);
    start = 1'b1; op = 3'b011; src_a = 32'd9; src_b = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("fix flush no done", dcount, 0);
    chk("fix flush busy", busy, 0);
    chk("fix flush hi", hi, 32'h1234);
    chk("fix flush lo", lo, 32'h5678);

    // flush with start in the same cycle: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; src_a = 32'd1; src_b = 32'd1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush+start busy", busy, 0);

    // reset mid-divide
    @(negedge clk);
    start = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid reset hi", hi, 0);
    chk("mid reset lo", lo, 0);
    chk("mid reset busy", busy, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("mid reset no done", dcount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
